// File: rtl/ascon_pack.sv
// ascon_pack: shared ASCON types and widths (reader FSM state, word and block widths)
package ascon_pack;
  typedef enum logic {IDLE, SEND} reader_state_t;
  localparam int WORD_W = 32;
  localparam int TAG_W = 128;
  localparam int RATE_W = 64;
endpackage

// File: rtl/ascon_block_reader.sv
// ascon_block_reader: captures a block on load_i and streams it MSB-word first over valid/ready (word_o/valid_o/last_o out, ready_i in, busy_o/done_o status)
module ascon_block_reader
  import ascon_pack::*;
#(
  parameter int nb_bits_g = TAG_W,
  parameter int word_bits_g = WORD_W
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   load_i,
  input  logic [nb_bits_g-1:0]   data_i,
  output logic                   busy_o,
  output logic [word_bits_g-1:0] word_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   last_o,
  output logic                   done_o
);
  localparam int N = nb_bits_g / word_bits_g;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  reader_state_t state, state_n;
  logic [nb_bits_g-1:0] sr, sr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic done_q, done_n;
  logic last;
  assign last = cnt == CW'(N - 1);
  assign valid_o = state == SEND;
  assign busy_o = state == SEND;
  assign last_o = valid_o && last;
  assign word_o = valid_o ? sr[nb_bits_g-1 -: word_bits_g] : '0;
  assign done_o = done_q;
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      done_q <= 1'b0;
    end else begin
      state <= state_n;
      sr <= sr_n;
      cnt <= cnt_n;
      done_q <= done_n;
    end
  end
  always_comb begin
    state_n = state;
    sr_n = sr;
    cnt_n = cnt;
    done_n = 1'b0;
    if (state == IDLE) begin
      if (load_i) begin
        sr_n = data_i;
        cnt_n = '0;
        state_n = SEND;
      end
    end else if (ready_i) begin
      state_n = last ? IDLE : SEND;
      sr_n = last ? '0 : sr << word_bits_g;
      cnt_n = last ? '0 : cnt + CW'(1);
      done_n = last;
    end
  end
endmodule
